uart_tx_cfg: RTL and testbench
==============================

// Module: uart_tx_cfg
// PURPOSE
//  Configurable UART transmitter: serialises DATA_W-bit words LSB first, optional
//  even/odd parity, 1 or 2 stop bits, selected per frame. Integrated baud counter
//  restarts on each accepted frame, so every bit lasts exactly DIV clocks.
//  Sits between the command/data path and the board TX pin; replaces the fixed 8N1 TX.
// PARAMETERS
//  CLK_HZ   100_000_000  system clock frequency (Hz)
//  BAUD     9600         line rate; DIV = CLK_HZ/BAUD (integer division), DIV >= 2 required
//  DATA_W   8            data bits per frame, legal 5..8
// PORTS
//  clk          in   1       system clock
//  reset        in   1       asynchronous, active-high reset
//  start        in   1       frame request; sampled only when busy=0
//  tx_data      in   DATA_W  word to send; latched on acceptance
//  parity_mode  in   2       0 none, 1 even, 2 odd, 3 reserved (= none); latched on acceptance
//  stop2        in   1       0 one stop bit, 1 two stop bits; latched on acceptance
//  tx           out  1       serial line, idle high
//  busy         out  1       high from cycle after acceptance until frame ends
//  tx_done      out  1       one-clock pulse at end of frame
// BEHAVIOUR
//  - Reset (async): tx=1, busy=0, tx_done=0, state IDLE, baud/bit counters 0.
//  - States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//  - IDLE: tx=1. Edge with start=1 accepts: latch tx_data, parity_mode, stop2;
//    clear baud counter; next cycle tx=0 (START), busy=1.
//  - Every bit state holds tx for exactly DIV clocks (baud tick at count DIV-1).
//  - DATA: DATA_W bits, bit 0 first; bit counter 0..DATA_W-1.
//  - PARITY (only modes 1/2): even -> ^data; odd -> ~^data, over latched DATA_W bits.
//  - STOP: tx=1 for DIV (stop2=0) or 2*DIV (stop2=1) clocks.
//  - N = 1 + DATA_W + P + S (P in {0,1}, S in {1,2}). At edge 1+N*DIV after the
//    accepting edge: state IDLE, busy=0, tx_done=1 for that single cycle.
//  - start while busy=1: ignored, no queueing. tx_data/config changes mid-frame: no effect.
//  - start held high: next frame accepted in the tx_done cycle; new start bit
//    follows exactly one extra idle-high clock after the final stop bit.
//  - Reset mid-frame: tx returns to 1 immediately, frame aborted, no tx_done pulse.
//  - All outputs registered; no combinational path from inputs to tx/busy/tx_done.
// STRUCTURE
//  - uart_pkg: PAR_NONE/PAR_EVEN/PAR_ODD localparams, tx state encoding
//    (shared with the future configurable receiver).
//  - Sub-module uart_baud_tick (DIV param; clk, reset, clr, tick): counter with
//    synchronous clear, one-clock tick every DIV clocks. FSM + shift register in top.
// TESTING  (bench: CLK_HZ=1_000_000, BAUD=100_000 -> DIV=10, DATA_W=8)
//  - 8N1 0x55: tx = 0,1,0,1,0,1,0,1,0,1 each 10 clocks; tx_done at clock 101, busy low then.
//  - 8E1 0x03: parity bit 0; 8O1 0x03: parity bit 1; tx_done at clock 111.
//  - 8O2 0xA7: data 1,1,1,0,0,1,0,1, parity 0, stop high 20 clocks; tx_done at clock 121.
//  - start pulsed at clock 30 mid-frame with new tx_data: ignored, waveform unchanged, one tx_done.
//  - start held high, 8N1 0x0F then 0xF0: second start bit falls at clock 102; two tx_done pulses.
//  - reset asserted at clock 45: tx=1, busy=0 same cycle; no tx_done; next frame after release correct.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode codes and transmitter state encoding,
// common to the configurable transmitter and the future receiver.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  // Mode 3 is reserved and behaves as no parity.
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud-rate divider: one-clock tick every DIV clocks, restartable with a
// synchronous clear so each frame starts on a fresh bit period.
module uart_baud_tick #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clr || (count_reg == LAST)) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + CW'(1);
    end
  end

  assign tick = (count_reg == LAST);

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: DATA_W data bits LSB first, optional even/odd
// parity and one or two stop bits, all chosen per frame when start is accepted.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 9600,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [1:0]        parity_mode,
  input  logic              stop2,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int BW  = $clog2(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  tx_state_t         state_reg, state_next;
  logic [DATA_W-1:0] shift_reg, shift_next;
  logic [BW-1:0]     bit_cnt_reg, bit_cnt_next;
  logic              par_en_reg, par_en_next;
  logic              par_bit_reg, par_bit_next;
  logic              stop2_reg, stop2_next;
  logic              accept;
  logic              tick;
  logic              line;
  logic              tx_reg, busy_reg, tx_done_reg;

  uart_baud_tick #(.DIV(DIV)) u_baud (
    .clk   (clk),
    .reset (reset),
    .clr   (accept),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      par_en_reg  <= 1'b0;
      par_bit_reg <= 1'b0;
      stop2_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
      par_en_reg  <= par_en_next;
      par_bit_reg <= par_bit_next;
      stop2_reg   <= stop2_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    par_en_next  = par_en_reg;
    par_bit_next = par_bit_reg;
    stop2_next   = stop2_reg;
    accept       = 1'b0;
    line         = 1'b1;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          accept       = 1'b1;
          state_next   = ST_START;
          shift_next   = tx_data;
          bit_cnt_next = '0;
          par_en_next  = parity_enabled(parity_mode);
          par_bit_next = (parity_mode == PAR_ODD) ? ~^tx_data : ^tx_data;
          stop2_next   = stop2;
        end
      end
      ST_START: begin
        line = 1'b0;
        if (tick) begin
          state_next   = ST_DATA;
          bit_cnt_next = '0;
        end
      end
      ST_DATA: begin
        line = shift_reg[0];
        if (tick) begin
          shift_next = shift_reg >> 1;
          if (bit_cnt_reg == LAST_BIT) begin
            state_next   = par_en_reg ? ST_PARITY : ST_STOP;
            bit_cnt_next = '0;
          end else begin
            bit_cnt_next = bit_cnt_reg + BW'(1);
          end
        end
      end
      ST_PARITY: begin
        line = par_bit_reg;
        if (tick) begin
          state_next   = ST_STOP;
          bit_cnt_next = '0;
        end
      end
      ST_STOP: begin
        // bit_cnt_reg counts completed stop bits when two are requested
        if (tick) begin
          if (!stop2_reg || (bit_cnt_reg != '0)) begin
            state_next = ST_IDLE;
          end else begin
            bit_cnt_next = BW'(1);
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs trail the state register by one clock; tx_done marks the first
  // output cycle after busy drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_reg      <= 1'b1;
      busy_reg    <= 1'b0;
      tx_done_reg <= 1'b0;
    end else begin
      tx_reg      <= line;
      busy_reg    <= (state_reg != ST_IDLE);
      tx_done_reg <= busy_reg && (state_reg == ST_IDLE);
    end
  end

  assign tx      = tx_reg;
  assign busy    = busy_reg;
  assign tx_done = tx_done_reg;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed self-checking bench for uart_tx_cfg at DIV=10, DATA_W=8.
// Clock index t counts rising edges after the accepting edge (t=0).
module tb_uart_tx_cfg;

  localparam int DIV = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [1:0] parity_mode = 2'd0;
  logic       stop2 = 1'b0;
  logic       tx, busy, tx_done;

  int n_checks = 0;
  int n_fail = 0;

  logic cap_tx   [0:255];
  logic cap_busy [0:255];
  logic cap_done [0:255];

  uart_tx_cfg #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .tx_data     (tx_data),
    .parity_mode (parity_mode),
    .stop2       (stop2),
    .tx          (tx),
    .busy        (busy),
    .tx_done     (tx_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic int frame_bits(input logic [1:0] pm, input logic s2);
    return 10 + (((pm == 2'd1) || (pm == 2'd2)) ? 1 : 0) + (s2 ? 1 : 0);
  endfunction

  // Expected line level t clocks after the accepting edge
  function automatic logic frame_line(input logic [7:0] d, input logic [1:0] pm,
                                      input logic s2, input int t);
    int b;
    b = (t - 1) / DIV;
    if ((t < 1) || (t > frame_bits(pm, s2) * DIV)) return 1'b1;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if ((b == 9) && ((pm == 2'd1) || (pm == 2'd2))) return (pm == 2'd1) ? ^d : ~^d;
    return 1'b1;
  endfunction

  task automatic launch(input logic [7:0] d, input logic [1:0] pm, input logic s2,
                        input logic hold);
    @(negedge clk);
    tx_data = d;
    parity_mode = pm;
    stop2 = s2;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  task automatic capture(input int n, input int hook_t, input logic [7:0] hook_d,
                         input int rel_t);
    for (int t = 1; t <= n; t++) begin
      @(posedge clk);
      #1;
      cap_tx[t] = tx;
      cap_busy[t] = busy;
      cap_done[t] = tx_done;
      if (t == hook_t) begin
        tx_data = hook_d;
        start = 1'b1;
      end
      if (t == rel_t) start = 1'b0;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({tx, busy, tx_done} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_hold tx/busy/done=%b%b%b expected 100", tx, busy, tx_done);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({tx, busy, tx_done} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_idle tx/busy/done=%b%b%b expected 100", tx, busy, tx_done);
    end
    $display("test_reset: tx=%b busy=%b tx_done=%b", tx, busy, tx_done);
  endtask

  task automatic test_8n1;
    launch(8'h55, 2'd0, 1'b0, 1'b0);
    capture(110, -1, 8'h00, -1);
    for (int t = 1; t <= 110; t++) begin
      n_checks += 3;
      if (cap_tx[t] !== frame_line(8'h55, 2'd0, 1'b0, t)) begin
        n_fail++;
        $display("FAIL 8n1_tx t=%0d got %b expected %b", t, cap_tx[t], frame_line(8'h55, 2'd0, 1'b0, t));
      end
      if (cap_busy[t] !== (t <= 100)) begin
        n_fail++;
        $display("FAIL 8n1_busy t=%0d got %b expected %b", t, cap_busy[t], (t <= 100));
      end
      if (cap_done[t] !== (t == 101)) begin
        n_fail++;
        $display("FAIL 8n1_done t=%0d got %b expected %b", t, cap_done[t], (t == 101));
      end
    end
    $display("test_8n1: 0x55 frame, done at 101=%b", cap_done[101]);
  endtask

  task automatic test_parity;
    logic [1:0] pm;
    logic       exp_par;
    for (int k = 0; k < 2; k++) begin
      pm = (k == 0) ? 2'd1 : 2'd2;
      exp_par = (k == 0) ? 1'b0 : 1'b1;
      launch(8'h03, pm, 1'b0, 1'b0);
      capture(115, -1, 8'h00, -1);
      n_checks++;
      if (cap_tx[95] !== exp_par) begin
        n_fail++;
        $display("FAIL parity_bit mode=%0d got %b expected %b", pm, cap_tx[95], exp_par);
      end
      for (int t = 1; t <= 115; t++) begin
        n_checks += 3;
        if (cap_tx[t] !== frame_line(8'h03, pm, 1'b0, t)) begin
          n_fail++;
          $display("FAIL parity_tx mode=%0d t=%0d got %b expected %b", pm, t, cap_tx[t], frame_line(8'h03, pm, 1'b0, t));
        end
        if (cap_busy[t] !== (t <= 110)) begin
          n_fail++;
          $display("FAIL parity_busy mode=%0d t=%0d got %b expected %b", pm, t, cap_busy[t], (t <= 110));
        end
        if (cap_done[t] !== (t == 111)) begin
          n_fail++;
          $display("FAIL parity_done mode=%0d t=%0d got %b expected %b", pm, t, cap_done[t], (t == 111));
        end
      end
      $display("test_parity: 0x03 mode=%0d parity bit=%b", pm, cap_tx[95]);
    end
  endtask

  task automatic test_8o2;
    launch(8'hA7, 2'd2, 1'b1, 1'b0);
    capture(125, -1, 8'h00, -1);
    for (int t = 1; t <= 125; t++) begin
      n_checks += 3;
      if (cap_tx[t] !== frame_line(8'hA7, 2'd2, 1'b1, t)) begin
        n_fail++;
        $display("FAIL 8o2_tx t=%0d got %b expected %b", t, cap_tx[t], frame_line(8'hA7, 2'd2, 1'b1, t));
      end
      if (cap_busy[t] !== (t <= 120)) begin
        n_fail++;
        $display("FAIL 8o2_busy t=%0d got %b expected %b", t, cap_busy[t], (t <= 120));
      end
      if (cap_done[t] !== (t == 121)) begin
        n_fail++;
        $display("FAIL 8o2_done t=%0d got %b expected %b", t, cap_done[t], (t == 121));
      end
    end
    $display("test_8o2: 0xA7 parity bit=%b, done at 121=%b", cap_tx[95], cap_done[121]);
  endtask

  task automatic test_midframe_start;
    int dones;
    dones = 0;
    launch(8'h55, 2'd0, 1'b0, 1'b0);
    capture(130, 29, 8'h00, 30);
    for (int t = 1; t <= 130; t++) begin
      if (cap_done[t] === 1'b1) dones++;
      n_checks += 2;
      if (cap_tx[t] !== frame_line(8'h55, 2'd0, 1'b0, t)) begin
        n_fail++;
        $display("FAIL midstart_tx t=%0d got %b expected %b", t, cap_tx[t], frame_line(8'h55, 2'd0, 1'b0, t));
      end
      if (cap_busy[t] !== (t <= 100)) begin
        n_fail++;
        $display("FAIL midstart_busy t=%0d got %b expected %b", t, cap_busy[t], (t <= 100));
      end
    end
    n_checks++;
    if (dones != 1) begin
      n_fail++;
      $display("FAIL midstart_done_count got %0d expected 1", dones);
    end
    $display("test_midframe_start: tx_done pulses=%0d", dones);
  endtask

  task automatic test_back_to_back;
    int  dones;
    logic exp_tx;
    dones = 0;
    launch(8'h0F, 2'd0, 1'b0, 1'b1);
    capture(215, 100, 8'hF0, 101);
    for (int t = 1; t <= 215; t++) begin
      if (cap_done[t] === 1'b1) dones++;
      exp_tx = (t <= 101) ? frame_line(8'h0F, 2'd0, 1'b0, t)
                          : frame_line(8'hF0, 2'd0, 1'b0, t - 101);
      n_checks += 3;
      if (cap_tx[t] !== exp_tx) begin
        n_fail++;
        $display("FAIL b2b_tx t=%0d got %b expected %b", t, cap_tx[t], exp_tx);
      end
      if (cap_busy[t] !== ((t <= 100) || ((t >= 102) && (t <= 201)))) begin
        n_fail++;
        $display("FAIL b2b_busy t=%0d got %b expected %b", t, cap_busy[t], ((t <= 100) || ((t >= 102) && (t <= 201))));
      end
      if (cap_done[t] !== ((t == 101) || (t == 202))) begin
        n_fail++;
        $display("FAIL b2b_done t=%0d got %b expected %b", t, cap_done[t], ((t == 101) || (t == 202)));
      end
    end
    n_checks += 2;
    if ({cap_tx[101], cap_tx[102]} !== 2'b10) begin
      n_fail++;
      $display("FAIL b2b_start_edge tx[101:102]=%b%b expected 10", cap_tx[101], cap_tx[102]);
    end
    if (dones != 2) begin
      n_fail++;
      $display("FAIL b2b_done_count got %0d expected 2", dones);
    end
    $display("test_back_to_back: second start bit at 102, tx_done pulses=%0d", dones);
  endtask

  task automatic test_reset_midframe;
    launch(8'h55, 2'd0, 1'b0, 1'b0);
    capture(44, -1, 8'h00, -1);
    n_checks++;
    if ({cap_busy[44], cap_tx[44]} !== 2'b10) begin
      n_fail++;
      $display("FAIL rstmid_pre busy/tx=%b%b expected 10", cap_busy[44], cap_tx[44]);
    end
    #1;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({tx, busy, tx_done} !== 3'b100) begin
      n_fail++;
      $display("FAIL rstmid_async tx/busy/done=%b%b%b expected 100", tx, busy, tx_done);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if ({tx, busy, tx_done} !== 3'b100) begin
        n_fail++;
        $display("FAIL rstmid_held cyc=%0d tx/busy/done=%b%b%b expected 100", i, tx, busy, tx_done);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    launch(8'h3C, 2'd1, 1'b1, 1'b0);
    capture(125, -1, 8'h00, -1);
    for (int t = 1; t <= 125; t++) begin
      n_checks += 3;
      if (cap_tx[t] !== frame_line(8'h3C, 2'd1, 1'b1, t)) begin
        n_fail++;
        $display("FAIL rstmid_next_tx t=%0d got %b expected %b", t, cap_tx[t], frame_line(8'h3C, 2'd1, 1'b1, t));
      end
      if (cap_busy[t] !== (t <= 120)) begin
        n_fail++;
        $display("FAIL rstmid_next_busy t=%0d got %b expected %b", t, cap_busy[t], (t <= 120));
      end
      if (cap_done[t] !== (t == 121)) begin
        n_fail++;
        $display("FAIL rstmid_next_done t=%0d got %b expected %b", t, cap_done[t], (t == 121));
      end
    end
    $display("test_reset_midframe: abort clean, next 8E2 0x3C done at 121=%b", cap_done[121]);
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_8o2();
    test_midframe_start();
    test_back_to_back();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
